// File: rtl/fp_norm_sched_if.sv
// fp_norm_sched_if: lane request bus and normalized result bus.
// master = requesters/consumer side, slave = scheduler side.
interface fp_norm_sched_if #(
   parameter int M     = 8,
   parameter int N     = 23,
   parameter int LANES = 4
);
   logic [LANES-1:0]           req_valid;
   logic [LANES*M-1:0]         req_exp;
   logic [LANES*(N+2)-1:0]     req_mant;
   logic [LANES-1:0]           req_ready;
   logic                       res_valid;
   logic                       res_ready;
   logic [$clog2(LANES)-1:0]   res_lane;
   logic [M-1:0]               res_exp;
   logic [N+1:0]               res_mant;
   logic                       res_zero;
   logic                       res_uflow;
   logic                       res_ovf;

   modport master (
      output req_valid, req_exp, req_mant, res_ready,
      input  req_ready, res_valid, res_lane, res_exp,
      input  res_mant, res_zero, res_uflow, res_ovf
   );

   modport slave (
      input  req_valid, req_exp, req_mant, res_ready,
      output req_ready, res_valid, res_lane, res_exp,
      output res_mant, res_zero, res_uflow, res_ovf
   );
endinterface

// File: rtl/fp_norm_sched.sv
// fp_norm_sched: round-robin lanes onto one shared normalizer, 2-stage pipe.
// Optional FP_NORM_SAT_EN: saturate exponent overflow to infinity.
module fp_norm_sched #(
   parameter int M     = 8,
   parameter int N     = 23,
   parameter int LANES = 4
) (
   input  logic           clk,
   input  logic           rst,
   fp_norm_sched_if.slave bus
);
   localparam int LW = $clog2(LANES);
   localparam int W  = N + 2;
   localparam int PW = $clog2(W);

   logic [LW-1:0] ptr_q, ptr_d;
   logic [LW-1:0] scan_idx;
   logic [LW-1:0] gnt_idx;
   logic          gnt_any;
   logic          out_en, s1_en, acc;

   logic          s1_v_q;
   logic [LW-1:0] s1_lane_q;
   logic [M-1:0]  s1_exp_q;
   logic [W-1:0]  s1_mant_q;

   logic          s2_v_q;
   logic [LW-1:0] lane_q;
   logic [M-1:0]  exp_q, exp_d;
   logic [W-1:0]  mant_q, mant_d;
   logic          zero_q, zero_d;
   logic          uflow_q, uflow_d;

   logic [PW-1:0] p;
   logic [M:0]    sh;
   logic [M:0]    e_dec;
   logic          is_zero, is_top;

   assign out_en = !s2_v_q || bus.res_ready;
   assign s1_en  = !s1_v_q || out_en;
   assign acc    = gnt_any && s1_en;

   // First valid lane at or after ptr, wrapping modulo LANES
   always_comb begin
      gnt_idx  = '0;
      gnt_any  = 1'b0;
      scan_idx = '0;
      for (int i = 0; i < LANES; i++) begin
         scan_idx = ptr_q + LW'(i);
         if (!gnt_any && bus.req_valid[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
         end
      end
   end

   assign bus.req_ready = acc ? (LANES'(1) << gnt_idx) : '0;
   assign ptr_d = acc ? gnt_idx + LW'(1) : ptr_q;

   // Arbiter pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   // Stage 1: capture the granted lane's operands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s1_lane_q <= '0;
         s1_exp_q  <= '0;
         s1_mant_q <= '0;
      end else if (s1_en) begin
         s1_v_q <= acc;
         if (acc) begin
            s1_lane_q <= gnt_idx;
            s1_exp_q  <= bus.req_exp[gnt_idx*M +: M];
            s1_mant_q <= bus.req_mant[gnt_idx*W +: W];
         end
      end
   end

`ifdef FP_NORM_SAT_EN
   logic [M:0] e_inc;
   logic       ovf_q, ovf_d;
   assign e_inc = {1'b0, s1_exp_q} + (M+1)'(1);
`endif

   // Leading-one detect, shift and exponent adjust
   always_comb begin
      p = '0;
      for (int i = 0; i < W; i++) begin
         if (s1_mant_q[i]) p = PW'(i);
      end
      sh      = (M+1)'(N) - (M+1)'(p);
      e_dec   = {1'b0, s1_exp_q} - sh;
      is_zero = (s1_mant_q == '0);
      is_top  = !is_zero && (p == PW'(W-1));
      exp_d   = '0;
      mant_d  = '0;
      zero_d  = 1'b0;
      uflow_d = 1'b0;
`ifdef FP_NORM_SAT_EN
      ovf_d   = 1'b0;
`endif
      unique case (1'b1)
         is_zero: zero_d = 1'b1;
         is_top: begin
`ifdef FP_NORM_SAT_EN
            if (e_inc >= {1'b0, {M{1'b1}}}) begin
               exp_d = '1;
               ovf_d = 1'b1;
            end else begin
               exp_d  = e_inc[M-1:0];
               mant_d = s1_mant_q >> 1;
            end
`else
            exp_d  = s1_exp_q + M'(1);
            mant_d = s1_mant_q >> 1;
`endif
         end
         (!is_zero && !is_top && !e_dec[M]): begin
            exp_d  = e_dec[M-1:0];
            mant_d = s1_mant_q << sh;
         end
         (!is_zero && !is_top && e_dec[M]): uflow_d = 1'b1;
         default: ;
      endcase
   end

   // Stage 2: output register, held while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v_q  <= 1'b0;
         lane_q  <= '0;
         exp_q   <= '0;
         mant_q  <= '0;
         zero_q  <= 1'b0;
         uflow_q <= 1'b0;
      end else if (out_en) begin
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            lane_q  <= s1_lane_q;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            zero_q  <= zero_d;
            uflow_q <= uflow_d;
         end
      end
   end

`ifdef FP_NORM_SAT_EN
   // Overflow flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   ovf_q <= 1'b0;
      else if (out_en && s1_v_q) ovf_q <= ovf_d;
   end
   assign bus.res_ovf = ovf_q;
`else
   assign bus.res_ovf = 1'b0;
`endif

   assign bus.res_valid = s2_v_q;
   assign bus.res_lane  = lane_q;
   assign bus.res_exp   = exp_q;
   assign bus.res_mant  = mant_q;
   assign bus.res_zero  = zero_q;
   assign bus.res_uflow = uflow_q;
endmodule

// File: doc/fp_norm_sched.md
# fp_norm_sched

Shared-normalizer scheduler for the convolution floating-point datapath. It accepts unnormalized exponent/mantissa pairs from up to LANES MAC lanes and arbitrates them round-robin onto a single normalization stage. The stage performs leading-one detection, mantissa shift and exponent adjust. It returns the normalized result tagged with its source lane through a two-stage, back-pressured pipeline that sits between the MAC accumulators and the result packer.

## Interface
- M, 8, exponent width
- N, 23, fraction width; mantissa operands are N+2 bits (bit N+1 = carry, bit N = hidden one)
- LANES, 4, number of requesters (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  LANES  per-lane request valid
- req_exp  in  LANES*M  lane i exponent at [i*M +: M]
- req_mant  in  LANES*(N+2)  lane i mantissa at [i*(N+2) +: N+2]
- req_ready  out  LANES  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_lane  out  clog2(LANES)  source lane of result
- res_exp  out  M  normalized exponent
- res_mant  out  N+2  normalized mantissa
- res_zero  out  1  input mantissa was zero
- res_uflow  out  1  exponent underflow, result flushed
- res_ovf  out  1  exponent overflow (see Configuration)

## Operation
- Arbiter: a round-robin pointer ptr, reset 0. The highest-priority lane is ptr, then ptr+1, … modulo LANES. req_ready is asserted for the first valid lane only when stage 1 can accept; otherwise it is all zero. On acceptance, ptr moves to granted lane + 1 (mod LANES). ptr is unchanged when nothing is accepted.
- Stage 1 registers s1_v, lane, exp, mant.
- Stage 2 (output register) computes from stage 1, with p = index of the most significant set bit of mant:
  - mant == 0: mant = 0, exp = 0, zero = 1.
  - p == N+1: mant >> 1, exp + 1.
  - p ≤ N and exp ≥ N−p: mant << (N−p), exp − (N−p).
  - p ≤ N and exp < N−p: mant = 0, exp = 0, uflow = 1.
- Exactly one of {normal, zero, uflow, ovf} applies per result. Flags are 0 unless their case applies.
- Exponent arithmetic is done at M+1 bits, so no silent borrow occurs.

## Timing
- out_en = !s2_v || res_ready.
  - Stage 2 loads from stage 1 when out_en; s2_v ← s1_v.
  - Stage 1 loads when !s1_v || out_en.
- Latency is 2 cycles: a request accepted at edge k appears on res_* after edge k+1 and is valid during cycle k+2. Throughput is 1 result per cycle while res_ready = 1.
- req_ready depends combinationally on res_ready. No combinational path runs from req_* to res_*.
- Under stall (res_valid && !res_ready), all res_* outputs hold stable. Once s1 is also full, req_ready = 0.
- Simultaneous grant and drain in the same cycle is permitted, with no bubble.
- Reset clears ptr, s1_v, s2_v and every res_* output (including flags) to 0. Reset mid-stream discards in-flight operations with no partial output.
- Requesters hold req_exp and req_mant stable while req_valid is high and the request is not yet accepted. req_valid may drop without acceptance.

## Configuration
- FP_NORM_SAT_EN
  - Defined: the p == N+1 case with exp+1 ≥ 2^M−1 gives exp = 2^M−1, mant = 0, ovf = 1 (infinity).
  - Undefined: exp+1 wraps modulo 2^M, mant is shifted normally, and res_ovf is tied to 0.

## Test plan
- Lane 0, exp 0x80, mant 0x0000001 → after 2 cycles: res_lane 0, exp 0x69, mant 0x0800000, all flags 0.
- Lane 2, exp 0x7F, mant 0x1000000 → exp 0x80, mant 0x0800000. Then exp 0x7F, mant 0x0000000 → zero 1, exp 0, mant 0.
- Lane 1, exp 0x05, mant 0x0000001 → uflow 1, exp 0, mant 0. Lane 1, exp 0x17, same mant → exp 0x00, mant 0x0800000, uflow 0.
- All 4 lanes valid continuously, res_ready 1 → grants 0,1,2,3,0,1. Results arrive in the same order, one per cycle.
- res_ready held 0 for 3 cycles with all lanes valid → res_* stable across the stall, at most 2 requests accepted, req_ready 0 thereafter. On release, results resume in order with no loss or duplication. Assert rst mid-stall → all outputs 0 next sample.
- exp 0xFF, mant 0x1000000:
  - FP_NORM_SAT_EN defined → exp 0xFF, mant 0, ovf 1.
  - FP_NORM_SAT_EN undefined → exp 0x00, mant 0x0800000, ovf 0.
